// File: rtl/ws2812b_meter_pkg.sv
// Shared widths, scaler FSM encodings and sample helpers for the WS2812B VU meter pipeline.
package ws2812b_meter_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int LEVEL_W     = 15;
  localparam int LED_COUNT_W = 16;
  localparam int PROD_W      = LEVEL_W + LED_COUNT_W;

  typedef enum logic [1:0] {
    SCL_STATE_IDLE = 2'd0,
    SCL_STATE_MUL  = 2'd1,
    SCL_STATE_DONE = 2'd2
  } sclState_t;

  // -32768 has no positive counterpart in 16 bits, so it saturates to full scale.
  function automatic logic [LEVEL_W-1:0] absSat(input logic signed [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] negS;
    negS = SAMPLE_W'(-s);
    if (!s[SAMPLE_W-1]) return s[LEVEL_W-1:0];
    if (negS[SAMPLE_W-1]) return {LEVEL_W{1'b1}};
    return negS[LEVEL_W-1:0];
  endfunction

  function automatic logic [LEVEL_W-1:0] maxLevel(input logic [LEVEL_W-1:0] x,
                                                  input logic [LEVEL_W-1:0] y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/seq_mult_15x16.sv
// Shift-add multiplier: consumes one multiplier bit per cycle, 16 cycles per 15x16 product.
module seq_mult_15x16
  import ws2812b_meter_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [LEVEL_W-1:0]     a,
  input  logic [LED_COUNT_W-1:0] b,
  output logic                   done,
  output logic [PROD_W-1:0]      product
);

  logic [PROD_W-1:0]      acc;
  logic [PROD_W-1:0]      mcand;
  logic [LED_COUNT_W-1:0] mplier;
  logic [3:0]             bitIdx;
  logic                   running;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (reset) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      bitIdx  <= '0;
      running <= 1'b0;
    end else if (start) begin
      acc     <= '0;
      mcand   <= {{(PROD_W-LEVEL_W){1'b0}}, a};
      mplier  <= b;
      bitIdx  <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      bitIdx <= bitIdx + 4'd1;
      if (bitIdx == 4'd15) running <= 1'b0;
    end
  end

  // High during the final step; product is complete from the next cycle on.
  assign done    = running && (bitIdx == 4'd15);
  assign product = acc;

endmodule

// File: rtl/vu_level_calc.sv
// VU level front end: windowed absolute peak, linear decay, and scaling of the held
// level to an LED count through a sequential multiplier.
module vu_level_calc
  import ws2812b_meter_pkg::*;
#(
  parameter int                 DELAY          = 1,
  parameter int                 WINDOW_SAMPLES = 1024,
  parameter logic [LEVEL_W-1:0] DECAY_STEP     = 15'd512
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic [LED_COUNT_W-1:0]     maxCount,
  output logic [LED_COUNT_W-1:0]     onCount,
  output logic                       onCount_valid,
  output logic [LEVEL_W-1:0]         level,
  output logic                       busy
);

  localparam int CNT_W = (WINDOW_SAMPLES > 1) ? $clog2(WINDOW_SAMPLES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW_SAMPLES - 1);
  // DELAY is a simulation-only hook; this RTL adds no delays, so it only gates legality.
  localparam bit PARAMS_OK = (WINDOW_SAMPLES >= 1) && (DELAY >= 0);

  logic [CNT_W-1:0]   sampleCnt;
  logic [LEVEL_W-1:0] peak;
  logic [LEVEL_W-1:0] mag;
  logic [LEVEL_W-1:0] winPeak;
  logic [LEVEL_W-1:0] decayed;
  logic [LEVEL_W-1:0] newLevel;
  logic [LEVEL_W-1:0] pendLevel;
  logic [LEVEL_W-1:0] mulA;
  logic               pending;
  logic               windowEnd;
  logic               resultAvail;
  logic               mulStart;
  logic               mulDone;
  logic [PROD_W-1:0]  product;
  logic               unusedProductLo;
  sclState_t          state;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    decayed = '0;
    if (level > DECAY_STEP) decayed = level - DECAY_STEP;
    mag         = absSat(sample);
    winPeak     = maxLevel(peak, mag);
    newLevel    = maxLevel(winPeak, decayed);
    windowEnd   = PARAMS_OK && sample_valid && (sampleCnt == LAST_IDX);
    resultAvail = windowEnd || pending;
    // A fresh window result is newer than anything parked in the pending register.
    mulA        = windowEnd ? newLevel : pendLevel;
    mulStart    = resultAvail && ((state == SCL_STATE_IDLE) || (state == SCL_STATE_DONE));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sampleCnt <= '0;
      peak      <= '0;
      level     <= '0;
    end else if (sample_valid) begin
      if (windowEnd) begin
        sampleCnt <= '0;
        peak      <= '0;
        level     <= newLevel;
      end else begin
        sampleCnt <= sampleCnt + CNT_W'(1);
        peak      <= winPeak;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= SCL_STATE_IDLE;
      busy          <= 1'b0;
      pending       <= 1'b0;
      pendLevel     <= '0;
      onCount       <= '0;
      onCount_valid <= 1'b0;
    end else begin
      onCount_valid <= 1'b0;
      case (state)
        SCL_STATE_IDLE: begin
          if (resultAvail) begin
            state   <= SCL_STATE_MUL;
            busy    <= 1'b1;
            pending <= 1'b0;
          end
        end
        SCL_STATE_MUL: begin
          // Only the newest result is kept; older unconsumed ones are dropped.
          if (windowEnd) begin
            pending   <= 1'b1;
            pendLevel <= newLevel;
          end
          if (mulDone) begin
            state <= SCL_STATE_DONE;
            busy  <= 1'b0;
          end
        end
        SCL_STATE_DONE: begin
          onCount       <= product[PROD_W-1 -: LED_COUNT_W];
          onCount_valid <= 1'b1;
          if (resultAvail) begin
            state   <= SCL_STATE_MUL;
            busy    <= 1'b1;
            pending <= 1'b0;
          end else begin
            state <= SCL_STATE_IDLE;
          end
        end
        default: begin
          state <= SCL_STATE_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  seq_mult_15x16 uMult (
    .clk     (clk),
    .reset   (reset),
    .start   (mulStart),
    .a       (mulA),
    .b       (maxCount),
    .done    (mulDone),
    .product (product)
  );

  assign unusedProductLo = ^product[PROD_W-LED_COUNT_W-1:0];

endmodule

// File: tb/tb_vu_level_calc.sv
// Self-checking bench for vu_level_calc: a cycle-level reference model pushes expected
// onCount results with their due cycle; a monitor pops and compares on each strobe.
module tb_vu_level_calc;

  localparam int          WIN  = 4;
  localparam logic [14:0] STEP = 15'd4096;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               sample_valid = 1'b0;
  logic signed [15:0] sample = '0;
  logic [15:0]        maxCount = '0;
  logic [15:0]        onCount;
  logic               onCount_valid;
  logic [14:0]        level;
  logic               busy;

  vu_level_calc #(
    .DELAY          (1),
    .WINDOW_SAMPLES (WIN),
    .DECAY_STEP     (STEP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_valid  (sample_valid),
    .sample        (sample),
    .maxCount      (maxCount),
    .onCount       (onCount),
    .onCount_valid (onCount_valid),
    .level         (level),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cnt;
    int          due;
  } exp_t;

  exp_t        expQ[$];
  int          nChecks = 0;
  int          nErrors = 0;
  int          cyc = 0;
  int          pulses = 0;
  logic [15:0] lastOnCount = '0;

  int mdlCnt = 0, mdlPeak = 0, mdlLevel = 0, mdlPendLevel = 0, mdlFreeAt = 0;
  bit mdlPend = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nChecks++;
    if (obs !== expv) begin
      nErrors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic int refAbs(input int s);
    if (s < -32767) return 32767;
    return (s < 0) ? -s : s;
  endfunction

  function automatic logic [15:0] refScale(input int lvl, input int mc);
    longint p;
    p = longint'(lvl) * longint'(mc);
    return 16'(p >>> 15);
  endfunction

  // Reference model: window end in cycle N starts a multiply unless one is in flight
  // (free again at its DONE cycle, start+17); the result is due in cycle start+18.
  always @(posedge clk) begin
    int m, wp, dec;
    if (reset) begin
      mdlCnt = 0; mdlPeak = 0; mdlLevel = 0; mdlPend = 1'b0; mdlFreeAt = 0;
      expQ.delete();
    end else begin
      if (sample_valid) begin
        m  = refAbs(int'(sample));
        wp = (m > mdlPeak) ? m : mdlPeak;
        if (mdlCnt == WIN - 1) begin
          dec = (mdlLevel > int'(STEP)) ? mdlLevel - int'(STEP) : 0;
          mdlLevel = (wp > dec) ? wp : dec;
          mdlCnt = 0;
          mdlPeak = 0;
          if (cyc >= mdlFreeAt) begin
            expQ.push_back('{refScale(mdlLevel, int'(maxCount)), cyc + 18});
            mdlFreeAt = cyc + 17;
            mdlPend = 1'b0;
          end else begin
            mdlPend = 1'b1;
            mdlPendLevel = mdlLevel;
          end
        end else begin
          mdlCnt++;
          mdlPeak = wp;
        end
      end
      if (mdlPend && cyc == mdlFreeAt) begin
        expQ.push_back('{refScale(mdlPendLevel, int'(maxCount)), cyc + 18});
        mdlFreeAt = cyc + 17;
        mdlPend = 1'b0;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (onCount_valid) begin
      pulses++;
      lastOnCount = onCount;
      if (expQ.size() == 0) begin
        check("unexpected_valid", 32'(onCount_valid), 32'd0);
      end else begin
        e = expQ.pop_front();
        check("onCount", 32'(onCount), 32'(e.cnt));
        check("latency", cyc, e.due);
      end
    end
  end

  task automatic sendWindow(input int s0, input int s1, input int s2, input int s3);
    int v[4];
    v = '{s0, s1, s2, s3};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample = 16'(v[i]);
    end
    @(negedge clk);
    sample_valid = 1'b0;
    sample = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expQ.size() != 0 || busy || mdlPend) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 32'(n < 300), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < %0d", cyc, 50000);
    $fatal(1);
  end

  initial begin
    int p0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_onCount", 32'(onCount), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(onCount_valid), 32'd0);

    // Full scale, including the -32768 saturation case.
    maxCount = 16'd60;
    sendWindow(-32768, -32768, -32768, -32768);
    check("fs_level", 32'(level), 32'd32767);
    drain();
    check("fs_onCount", 32'(lastOnCount), 32'd59);

    // Decay: one zero window, then eight more back to back.
    sendWindow(0, 0, 0, 0);
    check("decay1_level", 32'(level), 32'd28671);
    drain();
    check("decay1_onCount", 32'(lastOnCount), 32'd52);
    for (int i = 0; i < 8; i++) sendWindow(0, 0, 0, 0);
    check("decay8_level", 32'(level), 32'd0);
    drain();
    check("decay8_onCount", 32'(lastOnCount), 32'd0);

    // Half scale.
    sendWindow(100, -16384, 5, 0);
    check("half_level", 32'(level), 32'd16384);
    drain();
    check("half_onCount", 32'(lastOnCount), 32'd30);

    // Reset held three cycles in the middle of a multiply.
    sendWindow(-32768, -32768, -32768, -32768);
    repeat (4) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    p0 = pulses;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst2_onCount", 32'(onCount), 32'd0);
    check("rst2_level", 32'(level), 32'd0);
    check("rst2_busy", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);
    check("rst2_no_valid", pulses, p0);

    // Pending overwrite: three window ends inside one multiply; the middle one is dropped.
    maxCount = 16'd1000;
    p0 = pulses;
    sendWindow(1000, 1000, 1000, 1000);
    sendWindow(2000, 2000, 2000, 2000);
    sendWindow(3000, 3000, 3000, 3000);
    check("pend_level", 32'(level), 32'd3000);
    drain();
    check("pend_pulses", pulses - p0, 32'd2);
    check("pend_onCount", 32'(lastOnCount), 32'd91);

    // maxCount = 0 gives zero LEDs.
    maxCount = 16'd0;
    sendWindow(-32768, 0, 0, 0);
    check("mc0_level", 32'(level), 32'd32767);
    drain();
    check("mc0_onCount", 32'(lastOnCount), 32'd0);

    // maxCount changed mid-multiply must not affect the in-flight result.
    maxCount = 16'd60;
    sendWindow(16384, 0, 0, 0);
    check("mcchg_level", 32'(level), 32'd28671);
    repeat (3) @(negedge clk);
    maxCount = 16'd1000;
    drain();
    check("mcchg_onCount", 32'(lastOnCount), 32'd52);

    // Random windows against the reference model.
    for (int i = 0; i < 6; i++) begin
      maxCount = 16'($urandom_range(1, 2000));
      sendWindow(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
      check("rnd_level", 32'(level), 32'(mdlLevel));
      drain();
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
